// File: rtl/life_pkg.sv
// Shared types, rule presets and helpers for the life engine.
package life_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [8:0] CONWAY_BIRTH   = 9'b000001000;
  localparam logic [8:0] CONWAY_SURVIVE = 9'b000001100;
  localparam logic [8:0] HIGHLIFE_BIRTH = 9'b001001000;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/life_engine_if.sv
// Command/status bundle between the life engine and its controller.
interface life_engine_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
);
  logic                   load;
  logic [ROWS*COLS-1:0]   ingrid;
  logic                   start;
  logic                   abort;
  logic [GEN_W-1:0]       num_gens;
  logic [8:0]             birth_mask;
  logic [8:0]             survive_mask;
  logic                   wrap;
  logic                   stop_on_stable;
  logic [ROWS*COLS-1:0]   grid;
  logic                   busy;
  logic                   done;
  logic [GEN_W-1:0]       gen_count;
  logic                   stable;
  logic                   extinct;

  modport master (
    output load, ingrid, start, abort, num_gens, birth_mask, survive_mask,
           wrap, stop_on_stable,
    input  grid, busy, done, gen_count, stable, extinct
  );

  modport slave (
    input  load, ingrid, start, abort, num_gens, birth_mask, survive_mask,
           wrap, stop_on_stable,
    output grid, busy, done, gen_count, stable, extinct
  );
endinterface

// File: rtl/life_cell.sv
// One automaton cell: holds its state and evaluates the life-like rule.
module life_cell
  import life_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_nbr,
  input  logic [8:0] i_birth_mask,
  input  logic [8:0] i_survive_mask,
  input  logic       i_en,
  input  logic       i_ld,
  input  logic       i_ld_val,
  output logic       o_state,
  output logic       o_next
);
  logic       r_state;
  logic [3:0] w_n;

  assign w_n     = popcount8(i_nbr);
  assign o_next  = r_state ? i_survive_mask[w_n] : i_birth_mask[w_n];
  assign o_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_state <= 1'b0;
    else if (i_ld) r_state <= i_ld_val;
    else if (i_en) r_state <= o_next;
  end
endmodule

// File: rtl/life_engine.sv
// Cell array with edge/wrap neighbour routing plus the run-control FSM.
module life_engine
  import life_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  life_engine_if.slave  bus
);
  localparam int CELLS = ROWS * COLS;

  state_t             r_state, w_state_nx;
  logic [GEN_W-1:0]   r_remaining, w_remaining_nx;
  logic [GEN_W-1:0]   r_gen_count, w_gen_count_nx;
  logic               r_done, w_done_nx;
  logic               r_stable, w_stable_nx;
  logic               r_extinct, w_extinct_nx;
  logic [8:0]         r_birth, r_survive;
  logic               r_wrap, r_sos;
  logic               w_latch, w_en, w_ld;
  logic [CELLS-1:0]   w_grid, w_next;
  logic               w_same, w_next_zero;

  assign w_same      = (w_next == w_grid);
  assign w_next_zero = ~|w_next;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] w_nbr;
      for (genvar k = 0; k < 8; k++) begin : g_nbr
        // k walks the 3x3 window row-major, skipping its centre
        localparam int P   = (k < 4) ? k : k + 1;
        localparam int RN  = r + P / 3 - 1;
        localparam int CN  = c + P % 3 - 1;
        localparam bit OUT = (RN < 0) || (RN >= ROWS) || (CN < 0) || (CN >= COLS);
        localparam int IDX = ((RN + ROWS) % ROWS) * COLS + ((CN + COLS) % COLS);
        if (OUT) begin : g_edge
          assign w_nbr[k] = r_wrap & w_grid[IDX];
        end else begin : g_in
          assign w_nbr[k] = w_grid[IDX];
        end
      end
      life_cell u_cell (
        .clk            (clk),
        .rst            (rst),
        .i_nbr          (w_nbr),
        .i_birth_mask   (r_birth),
        .i_survive_mask (r_survive),
        .i_en           (w_en),
        .i_ld           (w_ld),
        .i_ld_val       (bus.ingrid[r*COLS+c]),
        .o_state        (w_grid[r*COLS+c]),
        .o_next         (w_next[r*COLS+c])
      );
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_remaining_nx  = r_remaining;
    w_gen_count_nx  = r_gen_count;
    w_done_nx       = 1'b0;
    w_stable_nx     = r_stable;
    w_extinct_nx    = r_extinct;
    w_latch         = 1'b0;
    w_en            = 1'b0;
    w_ld            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.load) begin
          w_ld           = 1'b1;
          w_gen_count_nx = '0;
          w_stable_nx    = 1'b0;
          w_extinct_nx   = 1'b0;
        end else if (bus.start) begin
          w_latch        = 1'b1;
          w_gen_count_nx = '0;
          w_stable_nx    = 1'b0;
          w_extinct_nx   = 1'b0;
          w_remaining_nx = bus.num_gens;
          if (bus.num_gens == '0) w_done_nx  = 1'b1;
          else                    w_state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_state_nx = ST_IDLE;
          w_done_nx  = 1'b1;
        end else begin
          w_en           = 1'b1;
          w_gen_count_nx = (&r_gen_count) ? r_gen_count : r_gen_count + 1'b1;
          w_remaining_nx = r_remaining - 1'b1;
          if ((r_remaining == GEN_W'(1)) || (r_sos && w_same)) begin
            w_state_nx   = ST_IDLE;
            w_done_nx    = 1'b1;
            w_stable_nx  = r_sos && w_same;
            w_extinct_nx = w_next_zero;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_gen_count <= '0;
      r_done      <= 1'b0;
      r_stable    <= 1'b0;
      r_extinct   <= 1'b0;
      r_birth     <= '0;
      r_survive   <= '0;
      r_wrap      <= 1'b0;
      r_sos       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_remaining <= w_remaining_nx;
      r_gen_count <= w_gen_count_nx;
      r_done      <= w_done_nx;
      r_stable    <= w_stable_nx;
      r_extinct   <= w_extinct_nx;
      if (w_latch) begin
        r_birth   <= bus.birth_mask;
        r_survive <= bus.survive_mask;
        r_wrap    <= bus.wrap;
        r_sos     <= bus.stop_on_stable;
      end
    end
  end

  assign bus.grid      = w_grid;
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.done      = r_done;
  assign bus.gen_count = r_gen_count;
  assign bus.stable    = r_stable;
  assign bus.extinct   = r_extinct;
endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine on an 8x8 grid against a 2-D array model.
module tb_life_engine;
  import life_pkg::*;

  localparam int R  = 8;
  localparam int C  = 8;
  localparam int GW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  life_engine_if #(.ROWS(R), .COLS(C), .GEN_W(GW)) bus ();
  life_engine #(.ROWS(R), .COLS(C), .GEN_W(GW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] setc(input logic [63:0] g, input int r, input int c);
    logic [63:0] t;
    t = g;
    t[r*C+c] = 1'b1;
    return t;
  endfunction

  function automatic logic [63:0] step(input logic [63:0] g, input logic [8:0] b,
                                       input logic [8:0] s, input logic w);
    logic [63:0] nx;
    nx = '0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (dr != 0 || dc != 0) begin
              if (rr < 0 || rr >= R || cc < 0 || cc >= C) begin
                if (w) begin
                  rr = (rr + R) % R;
                  cc = (cc + C) % C;
                  n += int'(g[rr*C+cc]);
                end
              end else begin
                n += int'(g[rr*C+cc]);
              end
            end
          end
        end
        nx[r*C+c] = g[r*C+c] ? s[n] : b[n];
      end
    end
    return nx;
  endfunction

  task automatic model_run(input logic [63:0] g0, input int n, input logic [8:0] b,
                           input logic [8:0] s, input logic w, input logic sos,
                           output logic [63:0] gf, output int gens,
                           output logic st, output logic ex);
    logic [63:0] g, nx;
    g = g0; gens = 0; st = 1'b0;
    for (int i = 0; i < n; i++) begin
      nx = step(g, b, s, w);
      gens++;
      if (sos && nx == g) begin
        st = 1'b1;
        g  = nx;
        break;
      end
      g = nx;
    end
    gf = g;
    ex = (gens > 0) ? (g == '0) : 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [63:0] p);
    bus.load   = 1'b1;
    bus.ingrid = p;
    @(posedge clk); #1;
    bus.load   = 1'b0;
    check({tag, "_load_grid"}, bus.grid, p);
    check({tag, "_load_gen"}, 64'(bus.gen_count), 64'd0);
    check({tag, "_load_flags"}, {62'd0, bus.stable, bus.extinct}, 64'd0);
  endtask

  task automatic do_run(input string tag, input logic [63:0] g0, input int n,
                        input logic [8:0] b, input logic [8:0] s,
                        input logic w, input logic sos);
    logic [63:0] gf;
    int          gens, cyc;
    logic        st, ex;
    model_run(g0, n, b, s, w, sos, gf, gens, st, ex);
    bus.start          = 1'b1;
    bus.num_gens       = GW'(n);
    bus.birth_mask     = b;
    bus.survive_mask   = s;
    bus.wrap           = w;
    bus.stop_on_stable = sos;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (n == 0) begin
      check({tag, "_busy0"}, 64'(bus.busy), 64'd0);
    end else begin
      check({tag, "_busy_first"}, {62'd0, bus.busy, bus.done}, 64'd2);
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
      end
      check({tag, "_busy_cycles"}, 64'(cyc), 64'(gens));
    end
    check({tag, "_done"}, {62'd0, bus.busy, bus.done}, 64'd1);
    check({tag, "_grid"}, bus.grid, gf);
    check({tag, "_gen"}, 64'(bus.gen_count), 64'(gens));
    check({tag, "_stable"}, 64'(bus.stable), 64'(st));
    check({tag, "_extinct"}, 64'(bus.extinct), 64'(ex));
  endtask

  initial begin
    logic [63:0] blink, glider, blk4, single, rep, p, e1, e2;
    bus.load = 1'b0; bus.ingrid = '0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.num_gens = '0; bus.birth_mask = '0; bus.survive_mask = '0;
    bus.wrap = 1'b0; bus.stop_on_stable = 1'b0;

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_grid", bus.grid, 64'd0);
    check("reset_status", {58'd0, bus.busy, bus.done, bus.stable, bus.extinct, 2'b00}, 64'd0);
    check("reset_gen", 64'(bus.gen_count), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    blink = setc(setc(setc('0, 2, 3), 3, 3), 4, 3);
    do_load("blinker", blink);
    do_run("blinker", blink, 2, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, 1'b0);
    check("blinker_orig", bus.grid, blink);
    check("blinker_gen2", 64'(bus.gen_count), 64'd2);
    do_run("b2b", blink, 1, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, 1'b0);
    check("b2b_horiz", bus.grid, setc(setc(setc('0, 3, 2), 3, 3), 3, 4));
    @(posedge clk); #1;
    check("done_pulse_len", 64'(bus.done), 64'd0);

    glider = setc(setc(setc(setc(setc('0, 0, 1), 1, 2), 2, 0), 2, 1), 2, 2);
    do_load("glw", glider);
    do_run("glider_wrap", glider, 32, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, 1'b0);
    check("glider_wrap_home", bus.grid, glider);
    do_load("gln", glider);
    do_run("glider_dead", glider, 32, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, 1'b0);

    blk4 = setc(setc(setc(setc('0, 3, 3), 3, 4), 4, 3), 4, 4);
    do_load("block", blk4);
    do_run("block", blk4, 10, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, 1'b1);
    check("block_flags", {61'd0, bus.gen_count[2:0] == 3'd1, bus.stable, bus.extinct}, 64'b110);

    single = setc('0, 4, 4);
    do_load("single", single);
    do_run("single", single, 5, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, 1'b1);
    check("single_flags", {61'd0, bus.gen_count[2:0] == 3'd2, bus.stable, bus.extinct}, 64'b111);

    p = {$urandom, $urandom};
    do_load("zero", p);
    do_run("zero", p, 0, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("zero_done_drop", 64'(bus.done), 64'd0);

    // Abort on the third busy cycle, with a load held during the run
    p  = {$urandom, $urandom};
    e1 = step(p, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0);
    e2 = step(e1, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0);
    do_load("abort", p);
    bus.start = 1'b1; bus.num_gens = GW'(100);
    bus.birth_mask = CONWAY_BIRTH; bus.survive_mask = CONWAY_SURVIVE;
    bus.wrap = 1'b0; bus.stop_on_stable = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("abort_busy1", 64'(bus.busy), 64'd1);
    bus.load = 1'b1; bus.ingrid = ~p;
    @(posedge clk); #1;
    check("abort_gen1_grid", bus.grid, e1);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    check("abort_busy3", {62'd0, bus.busy, bus.gen_count == GW'(2)}, 64'b11);
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.load = 1'b0;
    check("abort_status", {60'd0, bus.busy, bus.done, bus.stable, bus.extinct}, 64'b0100);
    check("abort_gen", 64'(bus.gen_count), 64'd2);
    check("abort_grid", bus.grid, e2);
    do_load("post_abort", ~p);

    rep = '0;
    rep = setc(setc(setc(rep, 1, 3), 1, 4), 1, 5);
    rep = setc(setc(rep, 2, 2), 2, 5);
    rep = setc(setc(rep, 3, 1), 3, 5);
    rep = setc(setc(rep, 4, 1), 4, 4);
    rep = setc(setc(setc(rep, 5, 1), 5, 2), 5, 3);
    do_load("highlife", rep);
    do_run("highlife", rep, 12, HIGHLIFE_BIRTH, CONWAY_SURVIVE, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      p = {$urandom, $urandom};
      do_load($sformatf("rnd%0d", i), p);
      do_run($sformatf("rnd%0d", i), p, int'($urandom_range(1, 20)),
             9'($urandom), 9'($urandom), 1'($urandom), 1'($urandom));
    end

    p = {$urandom, $urandom} | 64'h1;
    do_load("rstmid", p);
    bus.start = 1'b1; bus.num_gens = GW'(50);
    bus.birth_mask = CONWAY_BIRTH; bus.survive_mask = CONWAY_SURVIVE;
    bus.wrap = 1'b1; bus.stop_on_stable = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rstmid_busy_before", 64'(bus.busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_grid", bus.grid, 64'd0);
    check("rstmid_status", {60'd0, bus.busy, bus.done, bus.stable, bus.extinct}, 64'd0);
    check("rstmid_gen", 64'(bus.gen_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_no_done", {62'd0, bus.busy, bus.done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/life_engine.md
# life_engine

Parametrised cellular-automaton engine: a ROWS×COLS grid of registered cells advancing under a programmable life-like rule (birth/survive masks), with selectable toroidal or dead-edge boundary. A command FSM runs a requested number of generations, one per clock. It counts generations, optionally stops early on a stable or extinct grid, and reports completion with a one-cycle `done` pulse. It replaces the fixed-size, free-running Conway grid as the core of the life display pipeline.

## Interface
- `ROWS`, 16: grid rows, ≥3.
- `COLS`, 16: grid columns, ≥3.
- `GEN_W`, 16: width of generation request/count.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load`  in  1  copy `ingrid` into grid; honoured only when not busy.
- `ingrid`  in  ROWS*COLS  load pattern; cell (r,c) at bit r*COLS+c.
- `start`  in  1  begin a run; honoured only when not busy and `load`=0.
- `abort`  in  1  end a run at the next edge, without applying a generation.
- `num_gens`  in  GEN_W  generations to run; latched at start.
- `birth_mask`  in  9  bit k set: dead cell with k live neighbours is born; latched at start.
- `survive_mask`  in  9  bit k set: live cell with k live neighbours survives; latched at start.
- `wrap`  in  1  1 = toroidal edges, 0 = out-of-grid neighbours dead; latched at start.
- `stop_on_stable`  in  1  end the run on the first generation that leaves the grid unchanged; latched at start.
- `grid`  out  ROWS*COLS  current cell state, registered.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at end of run.
- `gen_count`  out  GEN_W  generations applied since last start/load.
- `stable`  out  1  last run ended because next==grid; sticky until start/load.
- `extinct`  out  1  grid all-zero at run end; sticky until start/load.

## Operation
- States: IDLE, RUN. `done` is a registered pulse, not a state.
- Reset (`rst`=0): grid=0, IDLE, `busy`=0, `done`=0, `gen_count`=0, `stable`=0, `extinct`=0, latched config=0.
- In IDLE, load has priority over start. Load: grid←`ingrid`; `gen_count`, `stable` and `extinct` cleared.
- In RUN, `load` and `start` are ignored.
- Start in IDLE: latch the config, clear counters/flags, remaining←`num_gens`.
  - `num_gens`=0: stay IDLE; `done` pulses next cycle with grid unchanged.
  - Otherwise enter RUN.
- Each RUN edge applies one generation to every cell simultaneously:
  - neighbour count n∈0..8, 4-bit, computed from current grid;
  - next = cell ? survive_mask[n] : birth_mask[n];
  - gen_count+1, saturating at all-ones; remaining−1.
- Run ends, with a return to IDLE and `done` pulsed, at the edge where:
  - remaining reaches 0, or
  - `stop_on_stable` is set and next==grid (that generation still counts; `stable`←1).
- `extinct`←(final grid==0) at run end.
- Abort in RUN: return to IDLE at the next edge, no generation applied, `done` pulses, flags not set. Abort in IDLE has no effect.
- Reset mid-run: immediate return to the reset state, no `done` pulse.

## Timing
- Start accepted at edge t, N≥1: generations are applied at edges t+1..t+N.
- `busy`=1 for the N cycles after edge t.
- `done`=1 for the one cycle after edge t+N, with `busy`=0 and the final grid visible.
- A new start is accepted in the same cycle that `done` is high.
- Neighbour logic is single-cycle combinational. No pipelining; grid output is glitch-free from registers.

## Structure
- Package `life_pkg`:
  - FSM state enum;
  - `CONWAY_BIRTH`=9'b000001000, `CONWAY_SURVIVE`=9'b000001100;
  - `HIGHLIFE_BIRTH`=9'b001001000.
- Sub-module `life_cell`:
  - inputs: 8 neighbours, masks, `en`, `ld`, `ld_val`, clk, rst;
  - the only place per-cell state is held.
  - The top level generates the array, handles edge/wrap neighbour muxing, and owns the FSM, counters and the next==grid reduction.

## Test plan
- Conway blinker (vertical, centre of 5×5), wrap=0, N=2: done after 2 busy cycles; grid equals the loaded pattern; gen_count=2; stable=0.
- Glider on 8×8, wrap=1, N=32: grid equals the loaded glider; gen_count=32. Same run with wrap=0: glider becomes a block in the corner.
- 2×2 block, stop_on_stable=1, N=10: done after 1 busy cycle; gen_count=1; stable=1; extinct=0.
- Single live cell, stop_on_stable=1, N=5: grid all-zero after gen 1; run ends at gen 2; stable=1; extinct=1.
- Abort at the 3rd busy cycle of an N=100 run: gen_count=2, done pulses, flags 0. A load asserted during the run is ignored; it is accepted in IDLE.
- Highlife (B36/S23) replicator seed, N=12, compared against the reference model. Drop `rst` mid-run: all outputs are 0 immediately, with no done pulse.
